// File: rtl/jtframe_sdram_resp.sv
// SDRAM request arbiter: turns 32-bit game reads, byte-wide download writes and
// periodic refresh into single-word transactions on a one-request memory port.
module jtframe_sdram_resp #(
    parameter int REFRESH_CNT = 390
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        downloading,
    input  logic        sdram_req,
    input  logic [21:0] sdram_addr,
    output logic        sdram_ack,
    output logic        data_rdy,
    output logic [31:0] data_read,
    input  logic        refresh_en,
    input  logic        prog_we,
    input  logic [21:0] prog_addr,
    input  logic [7:0]  prog_data,
    input  logic [1:0]  prog_mask,
    output logic        prog_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_refresh,
    output logic [21:0] mem_addr,
    output logic [15:0] mem_din,
    output logic [1:0]  mem_dqm,
    input  logic        mem_ok,
    input  logic [15:0] mem_dout
);

    localparam int CW = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
    localparam logic [CW-1:0] CNT_RELOAD = CW'(REFRESH_CNT - 1);

    typedef enum logic [2:0] {IDLE, RD_LO, RD_HI, WR, REF} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] refCnt_q, refCnt_d;
    logic          pend_q, pend_d;
    logic [21:0]   rdAddr_q, rdAddr_d;
    logic          sdramAck_q, sdramAck_d;
    logic          dataRdy_q, dataRdy_d;
    logic          progAck_q, progAck_d;
    logic [31:0]   dataRead_q, dataRead_d;
    logic          memReq_q, memReq_d;
    logic          memWe_q, memWe_d;
    logic          memRefresh_q, memRefresh_d;
    logic [21:0]   memAddr_q, memAddr_d;
    logic [15:0]   memDin_q, memDin_d;
    logic [1:0]    memDqm_q, memDqm_d;
    logic          memDone;

    // mem_ok only counts while a request is outstanding
    assign memDone = memReq_q & mem_ok;

    always_comb begin
        state_d      = state_q;
        refCnt_d     = (refCnt_q == '0) ? CNT_RELOAD : refCnt_q - CW'(1);
        pend_d       = pend_q;
        rdAddr_d     = rdAddr_q;
        sdramAck_d   = 1'b0;
        dataRdy_d    = 1'b0;
        progAck_d    = 1'b0;
        dataRead_d   = dataRead_q;
        memReq_d     = memReq_q;
        memWe_d      = memWe_q;
        memRefresh_d = memRefresh_q;
        memAddr_d    = memAddr_q;
        memDin_d     = memDin_q;
        memDqm_d     = memDqm_q;

        if (state_q == REF && memDone) pend_d = 1'b0;
        if (refCnt_q == '0)            pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (prog_we) begin
                    state_d      = WR;
                    memReq_d     = 1'b1;
                    memWe_d      = 1'b1;
                    memRefresh_d = 1'b0;
                    memAddr_d    = prog_addr;
                    memDin_d     = {prog_data, prog_data};
                    memDqm_d     = prog_mask;
                end else if (pend_q && (refresh_en || downloading)) begin
                    state_d      = REF;
                    memReq_d     = 1'b1;
                    memWe_d      = 1'b0;
                    memRefresh_d = 1'b1;
                end else if (sdram_req && !downloading) begin
                    state_d      = RD_LO;
                    sdramAck_d   = 1'b1;
                    rdAddr_d     = sdram_addr;
                    memReq_d     = 1'b1;
                    memWe_d      = 1'b0;
                    memRefresh_d = 1'b0;
                    memAddr_d    = sdram_addr;
                    memDqm_d     = 2'b00;
                end
            end
            RD_LO: begin
                if (memDone) begin
                    dataRead_d[15:0] = mem_dout;
                    memReq_d         = 1'b0;
                    state_d          = RD_HI;
                end
            end
            RD_HI: begin
                // Request dropped for one cycle after RD_LO; re-raise for the upper word
                if (!memReq_q) begin
                    memReq_d  = 1'b1;
                    memAddr_d = rdAddr_q + 22'd1;
                end else if (mem_ok) begin
                    dataRead_d[31:16] = mem_dout;
                    memReq_d          = 1'b0;
                    dataRdy_d         = 1'b1;
                    state_d           = IDLE;
                end
            end
            WR: begin
                if (memDone) begin
                    memReq_d  = 1'b0;
                    memWe_d   = 1'b0;
                    progAck_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            REF: begin
                if (memDone) begin
                    memReq_d     = 1'b0;
                    memRefresh_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            refCnt_q     <= CNT_RELOAD;
            pend_q       <= 1'b0;
            rdAddr_q     <= '0;
            sdramAck_q   <= 1'b0;
            dataRdy_q    <= 1'b0;
            progAck_q    <= 1'b0;
            dataRead_q   <= '0;
            memReq_q     <= 1'b0;
            memWe_q      <= 1'b0;
            memRefresh_q <= 1'b0;
            memAddr_q    <= '0;
            memDin_q     <= '0;
            memDqm_q     <= 2'b11;
        end else begin
            state_q      <= state_d;
            refCnt_q     <= refCnt_d;
            pend_q       <= pend_d;
            rdAddr_q     <= rdAddr_d;
            sdramAck_q   <= sdramAck_d;
            dataRdy_q    <= dataRdy_d;
            progAck_q    <= progAck_d;
            dataRead_q   <= dataRead_d;
            memReq_q     <= memReq_d;
            memWe_q      <= memWe_d;
            memRefresh_q <= memRefresh_d;
            memAddr_q    <= memAddr_d;
            memDin_q     <= memDin_d;
            memDqm_q     <= memDqm_d;
        end
    end

    assign sdram_ack   = sdramAck_q;
    assign data_rdy    = dataRdy_q;
    assign prog_ack    = progAck_q;
    assign data_read   = dataRead_q;
    assign mem_req     = memReq_q;
    assign mem_we      = memWe_q;
    assign mem_refresh = memRefresh_q;
    assign mem_addr    = memAddr_q;
    assign mem_din     = memDin_q;
    assign mem_dqm     = memDqm_q;

endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// Directed bench for jtframe_sdram_resp with a 2-cycle-latency memory model.
module tb_jtframe_sdram_resp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        downloading, sdram_req, refresh_en, prog_we;
    logic [21:0] sdram_addr, prog_addr;
    logic [7:0]  prog_data;
    logic [1:0]  prog_mask;
    logic        sdram_ack, data_rdy, prog_ack;
    logic [31:0] data_read;
    logic        mem_req, mem_we, mem_refresh;
    logic [21:0] mem_addr;
    logic [15:0] mem_din;
    logic [1:0]  mem_dqm;
    logic        mem_ok = 1'b0;
    logic [15:0] mem_dout = 16'h0;

    int passCnt = 0, failCnt = 0, totalCnt = 0;
    int ackCnt = 0, rdyCnt = 0, pAckCnt = 0, refCnt = 0, wrCnt = 0;
    int overlapCnt = 0, stabErr = 0, lat = 0;
    logic [21:0] addrQ[$];
    int          kindQ[$];
    logic [21:0] loAddr = '0;
    logic [15:0] loData = '0, hiData = '0;
    logic [21:0] wrAddr = '0;
    logic [15:0] wrDin = '0;
    logic [1:0]  wrDqm = '0;
    logic        wrWe = 1'b0;
    logic        prevReq = 1'b0, pWe = 1'b0, pRef = 1'b0;
    logic [21:0] pAddr = '0;
    logic [15:0] pDin = '0;
    logic [1:0]  pDqm = '0;

    jtframe_sdram_resp #(.REFRESH_CNT(8)) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr), .sdram_ack(sdram_ack),
        .data_rdy(data_rdy), .data_read(data_read), .refresh_en(refresh_en),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .prog_mask(prog_mask), .prog_ack(prog_ack), .mem_req(mem_req),
        .mem_we(mem_we), .mem_refresh(mem_refresh), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dqm(mem_dqm), .mem_ok(mem_ok), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    // Memory: answers every request two cycles after it is raised
    always @(negedge clk) begin
        mem_ok = 1'b0;
        if (!rst_n || !mem_req) begin
            lat = 0;
        end else begin
            lat++;
            if (lat == 2) begin
                lat = 0;
                mem_ok = 1'b1;
                mem_dout = (mem_addr == loAddr) ? loData : hiData;
                if (mem_we) begin
                    wrAddr = mem_addr; wrDin = mem_din; wrDqm = mem_dqm; wrWe = mem_we;
                    wrCnt++;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (sdram_ack) ackCnt++;
        if (data_rdy) rdyCnt++;
        if (prog_ack) pAckCnt++;
        if (sdram_ack && data_rdy) overlapCnt++;
        if (mem_req && !prevReq) begin
            addrQ.push_back(mem_addr);
            kindQ.push_back(mem_refresh ? 3 : (mem_we ? 2 : 1));
            if (mem_refresh) refCnt++;
        end
        if (mem_req && prevReq && (mem_addr !== pAddr || mem_we !== pWe ||
            mem_din !== pDin || mem_dqm !== pDqm || mem_refresh !== pRef)) stabErr++;
        prevReq = mem_req; pAddr = mem_addr; pWe = mem_we;
        pDin = mem_din; pDqm = mem_dqm; pRef = mem_refresh;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        totalCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock; the requester side drops each request once it is acknowledged
    task automatic applyStimulus();
        @(posedge clk);
        #1;
        if (sdram_ack) sdram_req = 1'b0;
        if (prog_ack) prog_we = 1'b0;
        if (mem_refresh) refresh_en = 1'b0;
    endtask

    function automatic int getCount(input int which);
        case (which)
            0:       return rdyCnt;
            1:       return pAckCnt;
            default: return refCnt;
        endcase
    endfunction

    task automatic waitCount(input string tag, input int which, input int target);
        int n = 0;
        while (getCount(which) < target && n < 80) begin
            applyStimulus();
            n++;
        end
        checkOutput(tag, 32'(getCount(which) >= target), 32'd1);
    endtask

    task automatic doRead(input logic [21:0] a, input logic [15:0] lo, input logic [15:0] hi);
        int r0 = rdyCnt;
        loAddr = a; loData = lo; hiData = hi;
        sdram_addr = a;
        sdram_req = 1'b1;
        waitCount("read_done", 0, r0 + 1);
        repeat (2) applyStimulus();
    endtask

    initial begin
        int a0, r0, p0, f0, o0;
        bit found;
        rst_n = 1'b0; downloading = 1'b0; sdram_req = 1'b0; refresh_en = 1'b0;
        prog_we = 1'b0; sdram_addr = '0; prog_addr = '0; prog_data = '0; prog_mask = '0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_sdram_ack", 32'(sdram_ack), 32'd0);
        checkOutput("rst_data_rdy", 32'(data_rdy), 32'd0);
        checkOutput("rst_prog_ack", 32'(prog_ack), 32'd0);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_refresh", 32'(mem_refresh), 32'd0);
        checkOutput("rst_data_read", data_read, 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_din", 32'(mem_din), 32'd0);
        checkOutput("rst_mem_dqm", 32'(mem_dqm), 32'd3);
        rst_n = 1'b1;
        applyStimulus();

        $display("[TB] basic read");
        a0 = ackCnt; r0 = rdyCnt; o0 = addrQ.size();
        doRead(22'h000010, 16'h1234, 16'hABCD);
        checkOutput("read_data", data_read, 32'hABCD1234);
        checkOutput("read_ack_count", 32'(ackCnt - a0), 32'd1);
        checkOutput("read_rdy_count", 32'(rdyCnt - r0), 32'd1);
        checkOutput("read_lo_addr", 32'(addrQ[o0]), 32'h000010);
        checkOutput("read_hi_addr", 32'(addrQ[o0 + 1]), 32'h000011);

        $display("[TB] address wrap");
        o0 = addrQ.size();
        doRead(22'h3FFFFF, 16'h5555, 16'h0F0F);
        checkOutput("wrap_lo_addr", 32'(addrQ[o0]), 32'h3FFFFF);
        checkOutput("wrap_hi_addr", 32'(addrQ[o0 + 1]), 32'h000000);
        checkOutput("wrap_data", data_read, 32'h0F0F5555);

        $display("[TB] download write");
        a0 = ackCnt; p0 = pAckCnt;
        downloading = 1'b1; sdram_addr = 22'h000020; sdram_req = 1'b1;
        prog_addr = 22'h000005; prog_data = 8'h5A; prog_mask = 2'b10; prog_we = 1'b1;
        waitCount("write_done", 1, p0 + 1);
        repeat (20) applyStimulus();
        checkOutput("write_addr", 32'(wrAddr), 32'h000005);
        checkOutput("write_we", 32'(wrWe), 32'd1);
        checkOutput("write_din", 32'(wrDin), 32'h5A5A);
        checkOutput("write_dqm", 32'(wrDqm), 32'd2);
        checkOutput("write_prog_ack_count", 32'(pAckCnt - p0), 32'd1);
        checkOutput("download_no_sdram_ack", 32'(ackCnt - a0), 32'd0);
        sdram_req = 1'b0;
        applyStimulus();
        downloading = 1'b0;
        repeat (10) applyStimulus();

        $display("[TB] write/refresh/read collision");
        a0 = ackCnt; r0 = rdyCnt; p0 = pAckCnt; f0 = refCnt; o0 = addrQ.size();
        loAddr = 22'h000040; loData = 16'h1111; hiData = 16'h2222;
        prog_addr = 22'h000007; prog_data = 8'h3C; prog_mask = 2'b00; prog_we = 1'b1;
        sdram_addr = 22'h000040; sdram_req = 1'b1; refresh_en = 1'b1;
        waitCount("collision_done", 0, r0 + 1);
        checkOutput("collision_first_wr", 32'(kindQ[o0]), 32'd2);
        checkOutput("collision_second_ref", 32'(kindQ[o0 + 1]), 32'd3);
        checkOutput("collision_third_rd", 32'(kindQ[o0 + 2]), 32'd1);
        checkOutput("collision_prog_ack", 32'(pAckCnt - p0), 32'd1);
        checkOutput("collision_sdram_ack", 32'(ackCnt - a0), 32'd1);
        checkOutput("collision_refresh", 32'(refCnt - f0), 32'd1);
        checkOutput("collision_data", data_read, 32'h22221111);
        repeat (2) applyStimulus();

        $display("[TB] refresh gating");
        r0 = rdyCnt; f0 = refCnt;
        for (int i = 0; i < 3; i++) begin
            doRead(22'h000100 + 22'(2 * i), 16'h7000 + 16'(i), 16'h8000 + 16'(i));
            repeat (6) applyStimulus();
        end
        checkOutput("gated_no_refresh", 32'(refCnt - f0), 32'd0);
        checkOutput("gated_reads_served", 32'(rdyCnt - r0), 32'd3);
        checkOutput("gated_last_data", data_read, 32'h80027002);
        refresh_en = 1'b1;
        waitCount("refresh_after_enable", 2, f0 + 1);
        repeat (30) applyStimulus();
        checkOutput("single_refresh", 32'(refCnt - f0), 32'd1);

        $display("[TB] reset during upper read");
        a0 = ackCnt; r0 = rdyCnt;
        loAddr = 22'h000080; loData = 16'hDEAD; hiData = 16'hBEEF;
        sdram_addr = 22'h000080; sdram_req = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            applyStimulus();
            if (mem_req && mem_addr == 22'h000081) found = 1'b1;
        end
        checkOutput("reached_rd_hi", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("reset_mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset_data_read", data_read, 32'd0);
        checkOutput("reset_mem_dqm", 32'(mem_dqm), 32'd3);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (10) applyStimulus();
        checkOutput("reset_no_data_rdy", 32'(rdyCnt - r0), 32'd0);
        checkOutput("reset_single_ack", 32'(ackCnt - a0), 32'd1);
        doRead(22'h000090, 16'hCAFE, 16'hF00D);
        checkOutput("post_reset_data", data_read, 32'hF00DCAFE);
        checkOutput("post_reset_rdy", 32'(rdyCnt - r0), 32'd1);

        checkOutput("ack_rdy_overlap", 32'(overlapCnt), 32'd0);
        checkOutput("stable_while_req", 32'(stabErr), 32'd0);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule

// File: doc/jtframe_sdram_resp.md
JTFRAME_SDRAM_RESP -- requirements
Module: jtframe_sdram_resp

Interface
REQ-001 SHALL have parameter REFRESH_CNT, default 390, clk cycles between refresh requests.
REQ-002 SHALL have ports (name direction width meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- downloading  in  1  ROM download in progress.
- sdram_req  in  1  read request; requester holds it high until sdram_ack.
- sdram_addr  in  22  16-bit word address of the read.
- sdram_ack  out  1  one-cycle pulse: read accepted.
- data_rdy  out  1  one-cycle pulse: data_read valid.
- data_read  out  32  {word addr+1, word addr}.
- refresh_en  in  1  requester permits refresh now.
- prog_we  in  1  download write request; held high until prog_ack.
- prog_addr  in  22  word address of the write.
- prog_data  in  8  write byte.
- prog_mask  in  2  active-low byte enables.
- prog_ack  out  1  one-cycle pulse: write completed.
- mem_req  out  1  memory-port request.
- mem_we  out  1  1 = write, 0 = read.
- mem_refresh  out  1  request is a refresh cycle.
- mem_addr  out  22  memory word address.
- mem_din  out  16  write data.
- mem_dqm  out  2  active-low byte enables.
- mem_ok  in  1  one-cycle completion from memory.
- mem_dout  in  16  read data, valid when mem_ok = 1.

Function
REQ-003 SHALL implement the FSM states IDLE, RD_LO, RD_HI, WR and REF.
REQ-004 SHALL, in IDLE, select by fixed priority: prog_we → WR; else pending refresh with (refresh_en|downloading) → REF; else sdram_req & !downloading → RD_LO; else stay in IDLE.
REQ-005 SHALL ignore sdram_req while downloading = 1 (no sdram_ack is produced).
REQ-006 SHALL pulse sdram_ack in the cycle after IDLE accepts a read, and latch sdram_addr at that point.
REQ-007 SHALL issue a memory read at the latched address in RD_LO, then at latched address + 1 (mod 2^22, so 3FFFFF wraps to 000000) in RD_HI.
REQ-008 SHALL store mem_dout from RD_LO into data_read[15:0] and from RD_HI into data_read[31:16].
REQ-009 SHALL pulse data_rdy in the cycle after the RD_HI mem_ok, then return to IDLE.
REQ-010 SHALL, in WR, drive mem_we = 1, mem_addr = prog_addr, mem_din = {prog_data, prog_data} and mem_dqm = prog_mask.
REQ-011 SHALL pulse prog_ack in the cycle after the WR mem_ok, then return to IDLE.
REQ-012 SHALL, in REF, drive mem_refresh = 1 with mem_we = 0, and clear the pending-refresh flag on its mem_ok.
REQ-013 SHALL follow the memory handshake:
- mem_req rises on state entry and stays high until mem_ok is sampled.
- mem_req falls in the cycle after mem_ok; each new state then re-raises it.
- mem_addr, mem_we, mem_din, mem_dqm and mem_refresh stay stable while mem_req = 1.
REQ-014 SHALL use a free-running down-counter:
- reload to REFRESH_CNT-1 on reaching 0, setting the pending-refresh flag.
- the flag saturates: at most one refresh is pending.
- counting continues in every state.
REQ-015 SHALL never preempt an operation in progress; requests arriving mid-operation are evaluated at the next IDLE.
REQ-016 SHALL give one cycle minimum in IDLE between operations; data_rdy and the next sdram_ack never coincide.
REQ-017 SHALL treat a mem_ok that arrives while mem_req = 0 as a no-op.

Reset
REQ-018 SHALL, while rst_n = 0, asynchronously force:
- state = IDLE; pending flag = 0; refresh counter = REFRESH_CNT-1.
- sdram_ack, data_rdy, prog_ack, mem_req, mem_we, mem_refresh = 0.
- data_read, mem_addr, mem_din = 0; mem_dqm = 2'b11.
REQ-019 SHALL abandon any operation when reset asserts mid-transfer, with no ack or data_rdy pulse emitted after release.

Verification
REQ-020 Read, memory returning 1234 then ABCD with 2-cycle latency: sdram_req, addr 000010 → one sdram_ack; mem_addr 000010 then 000011; data_read = ABCD1234; one data_rdy.
REQ-021 Wrap: sdram_addr 3FFFFF → second mem_addr = 000000.
REQ-022 Write: downloading = 1, prog_we, addr 000005, data 5A, mask 10 → mem_we = 1, mem_din = 5A5A, mem_dqm = 10, one prog_ack; a sdram_req held throughout gets no ack.
REQ-023 Same-cycle collision: prog_we, sdram_req and pending refresh (refresh_en = 1) → order WR, REF, RD; exactly one of each ack/pulse.
REQ-024 Refresh gating: refresh_en = 0, downloading = 0 with REFRESH_CNT = 8 → no mem_refresh while reads keep being served; refresh_en = 1 → exactly one refresh despite multiple elapsed periods.
REQ-025 Reset: rst_n low during RD_HI → mem_req = 0 immediately; no data_rdy after release; next read works normally.
